// File: rtl/led_pattern_sequencer.sv
// MMIO slot core that plays a software-loaded table of (LED mask, duration) steps.
// A prescaler stretches every duration unit to P+1 clocks; the sequence stops or loops at its end.
module led_pattern_sequencer #(
  parameter int NUM_STEPS = 8,
  parameter int LED_W     = 5,
  parameter int DUR_W     = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             read,
  input  logic             write,
  input  logic [4:0]       addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  output logic [LED_W-1:0] led_out,
  output logic             busy,
  output logic             done_tick
);
  localparam int IW = $clog2(NUM_STEPS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [LED_W-1:0] step_mask [NUM_STEPS];
  logic [DUR_W-1:0] step_dur  [NUM_STEPS];
  logic [15:0]      prescale, pcnt;
  logic [DUR_W-1:0] ucnt, run_dur;
  logic [3:0]       cur_step, step_nxt;
  logic             loop, done;

  logic             wr_en, go, stop, step_hit, is_last, unit_end, step_end;
  logic [LED_W-1:0] load_mask;
  logic [DUR_W-1:0] load_dur;
  logic             unused_bits;

  assign unused_bits = ^{read, wr_data};

  assign wr_en    = cs && write;
  assign go       = wr_en && (addr == 5'd0) && wr_data[0];
  assign stop     = wr_en && (addr == 5'd0) && wr_data[2];
  assign step_hit = addr[4] && (int'(addr[3:0]) < NUM_STEPS);

  assign load_mask = step_mask[cur_step[IW-1:0]];
  assign load_dur  = step_dur[cur_step[IW-1:0]];
  assign is_last   = (int'(cur_step) == NUM_STEPS - 1);
  // >= rather than == so a PRESCALE shrunk below the live count still wraps
  assign unit_end  = (pcnt >= prescale);
  assign step_end  = unit_end && (ucnt >= run_dur - DUR_W'(1));

  assign busy = (state == S_LOAD) || (state == S_RUN);

  always_comb begin
    state_nxt = state;
    step_nxt  = cur_step;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (go) begin
          state_nxt = S_LOAD;
          step_nxt  = '0;
        end
      end
      S_LOAD: begin
        if (load_dur == '0) begin
          if (cur_step != '0 && loop) begin
            state_nxt = S_LOAD;
            step_nxt  = '0;
          end else begin
            state_nxt = S_DONE;
          end
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (step_end) begin
          if (!is_last) begin
            state_nxt = S_LOAD;
            step_nxt  = cur_step + 4'd1;
          end else if (loop) begin
            state_nxt = S_LOAD;
            step_nxt  = '0;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (stop) begin
      state_nxt = S_IDLE;
      step_nxt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_step  <= '0;
      led_out   <= '0;
      done      <= 1'b0;
      done_tick <= 1'b0;
      loop      <= 1'b0;
      prescale  <= '0;
      pcnt      <= '0;
      ucnt      <= '0;
      run_dur   <= '0;
      for (int i = 0; i < NUM_STEPS; i++) begin
        step_mask[i] <= '0;
        step_dur[i]  <= '0;
      end
    end else begin
      state     <= state_nxt;
      cur_step  <= step_nxt;
      done_tick <= (state_nxt == S_DONE) && (state != S_DONE);

      if (state_nxt == S_DONE)
        done <= 1'b1;
      else if (state_nxt == S_LOAD && (state == S_IDLE || state == S_DONE))
        done <= 1'b0;

      if (state_nxt == S_IDLE || state_nxt == S_DONE)
        led_out <= '0;
      else if (state == S_LOAD && state_nxt == S_RUN)
        led_out <= load_mask;

      // duration is latched at LOAD so a STEP rewrite only lands on the next pass
      if (state == S_LOAD) begin
        pcnt    <= '0;
        ucnt    <= '0;
        run_dur <= load_dur;
      end else if (state == S_RUN) begin
        if (unit_end) begin
          pcnt <= '0;
          if (!step_end) ucnt <= ucnt + DUR_W'(1);
        end else begin
          pcnt <= pcnt + 16'd1;
        end
      end

      if (wr_en) begin
        if (addr == 5'd0) loop <= wr_data[1];
        if (addr == 5'd2) prescale <= wr_data[15:0];
        if (step_hit) begin
          step_mask[addr[IW-1:0]] <= wr_data[LED_W-1:0];
          step_dur[addr[IW-1:0]]  <= wr_data[8 +: DUR_W];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (step_hit) begin
      rd_data[8 +: DUR_W]   = step_dur[addr[IW-1:0]];
      rd_data[LED_W-1:0]    = step_mask[addr[IW-1:0]];
    end else begin
      unique case (addr)
        5'd0:    rd_data[1] = loop;
        5'd1:    rd_data[7:0] = {cur_step, 2'b00, done, busy};
        5'd2:    rd_data[15:0] = prescale;
        default: rd_data = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer: hand-computed LED/busy/done_tick traces per cycle.
module tb_led_pattern_sequencer;
  logic        clk = 1'b0;
  logic        reset, cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic [4:0]  led_out;
  logic        busy, done_tick;
  int          total = 0, bad = 0;

  led_pattern_sequencer #(.NUM_STEPS(8), .LED_W(5), .DUR_W(24)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .led_out(led_out), .busy(busy),
    .done_tick(done_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic now_chk(input string tag, input logic [4:0] led, input bit b, input bit t);
    chk({tag, ".led"}, 32'(led_out), 32'(led));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".tick"}, 32'(done_tick), 32'(t));
  endtask

  task automatic cyc(input string tag, input logic [4:0] led, input bit b, input bit t);
    @(negedge clk);
    now_chk(tag, led, b, t);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0; wr_data = '0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] e);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; addr = a;
    #1 chk(tag, rd_data, e);
    cs = 1'b0; read = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: reset state
    now_chk("rst", 5'h00, 1'b0, 1'b0);
    rd("rst.ctrl", 5'd0, 32'h0);
    rd("rst.status", 5'd1, 32'h0);
    rd("rst.pre", 5'd2, 32'h0);
    rd("rst.unmapped", 5'd3, 32'h0);
    for (int i = 0; i < 8; i++) rd($sformatf("rst.step%0d", i), 5'(16 + i), 32'h0);
    rd("rst.step8_unmapped", 5'd24, 32'h0);
    wr(5'd3, 32'hFFFF_FFFF);
    wr(5'd1, 32'hFFFF_FFFF);
    rd("ro.status", 5'd1, 32'h0);
    rd("ro.unmapped", 5'd3, 32'h0);

    // 2: two steps, P=1, no loop
    wr(5'd2, 32'h1);
    wr(5'd16, 32'h0000_0301);
    wr(5'd17, 32'h0000_0202);
    rd("rb.step0", 5'd16, 32'h0000_0301);
    rd("rb.pre", 5'd2, 32'h1);
    wr(5'd0, 32'h1);
    now_chk("t2.load0", 5'h00, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc("t2.run0", 5'h01, 1'b1, 1'b0);
    cyc("t2.load1", 5'h01, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc("t2.run1", 5'h02, 1'b1, 1'b0);
    cyc("t2.load2", 5'h02, 1'b1, 1'b0);
    cyc("t2.done", 5'h00, 1'b0, 1'b1);
    cyc("t2.done2", 5'h00, 1'b0, 1'b0);
    rd("t2.status", 5'd1, 32'h0000_0022);

    // 3: same table looping; step2 D=0 costs its own LOAD before step0 reloads
    wr(5'd0, 32'h2);
    rd("t3.ctrl", 5'd0, 32'h2);
    wr(5'd0, 32'h3);
    now_chk("t3.load0", 5'h00, 1'b1, 1'b0);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 6; i++) cyc("t3.run0", 5'h01, 1'b1, 1'b0);
      cyc("t3.load1", 5'h01, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cyc("t3.run1", 5'h02, 1'b1, 1'b0);
      cyc("t3.load2", 5'h02, 1'b1, 1'b0);
      cyc("t3.reload0", 5'h02, 1'b1, 1'b0);
    end
    cyc("t3.run0b", 5'h01, 1'b1, 1'b0);
    wr(5'd0, 32'h4);
    now_chk("t3.stop", 5'h00, 1'b0, 1'b0);
    rd("t3.status", 5'd1, 32'h0);

    // 4: eight steps of one clock, P=0
    wr(5'd2, 32'h0);
    for (int i = 0; i < 8; i++) wr(5'(16 + i), 32'h100 | 32'(i + 1));
    wr(5'd0, 32'h1);
    now_chk("t4.load0", 5'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("t4.run%0d", i), 5'(i + 1), 1'b1, 1'b0);
      if (i < 7) cyc($sformatf("t4.load%0d", i + 1), 5'(i + 1), 1'b1, 1'b0);
    end
    cyc("t4.done", 5'h00, 1'b0, 1'b1);
    rd("t4.status", 5'd1, 32'h0000_0072);

    // 5: stop mid-RUN at step 2, then go+stop together
    wr(5'd2, 32'h3);
    wr(5'd0, 32'h1);
    now_chk("t5.load0", 5'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc("t5.run0", 5'h01, 1'b1, 1'b0);
    cyc("t5.load1", 5'h01, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc("t5.run1", 5'h02, 1'b1, 1'b0);
    cyc("t5.load2", 5'h02, 1'b1, 1'b0);
    cyc("t5.run2", 5'h03, 1'b1, 1'b0);
    wr(5'd0, 32'h4);
    now_chk("t5.stop", 5'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc("t5.idle", 5'h00, 1'b0, 1'b0);
    rd("t5.status", 5'd1, 32'h0);
    wr(5'd0, 32'h5);
    now_chk("t5.gostop", 5'h00, 1'b0, 1'b0);
    cyc("t5.gostop2", 5'h00, 1'b0, 1'b0);
    rd("t5.status2", 5'd1, 32'h0);

    // 6: empty table, then stop keeps done
    wr(5'd16, 32'h0000_0001);
    wr(5'd0, 32'h1);
    now_chk("t6.load", 5'h00, 1'b1, 1'b0);
    cyc("t6.done", 5'h00, 1'b0, 1'b1);
    cyc("t6.done2", 5'h00, 1'b0, 1'b0);
    rd("t6.status", 5'd1, 32'h0000_0002);
    wr(5'd0, 32'h4);
    rd("t6.stopkeep", 5'd1, 32'h0000_0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
